// File: rtl/morty_if_stage.sv
// morty_if_stage: instruction-fetch stage of the Morty RV32I pipeline.
// Owns the PC, drives a Wishbone-classic instruction port and registers the
// fetched word, its PC and any fetch exception into the IF/ID boundary.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   pc_redirect_i, pc_target_i   load new PC (branch/jump/trap/xret)
//   if_stall_i                   ID cannot accept; IF/ID holds
//   iport_*                      Wishbone-classic instruction master
//   id_*                         IF/ID boundary registers to decode
//
// state     | meaning
// S_IDLE    | one quiet cycle after reset, then fetch
// S_FETCH   | request at pc outstanding (or misaligned pc awaiting report)
// S_HOLD    | word parked in skid buffer, waiting for ID to unstall
// S_DISCARD | redirected while busy; finish old request and drop it
// S_HALT    | fetch error reported, wait for redirect
module morty_if_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_redirect_i,
  input  logic [31:0] pc_target_i,
  input  logic        if_stall_i,
  output logic [31:0] iport_addr_o,
  output logic        iport_cyc_o,
  output logic        iport_stb_o,
  input  logic [31:0] iport_dat_i,
  input  logic        iport_ack_i,
  input  logic        iport_err_i,
  output logic [31:0] id_instruction_o,
  output logic [31:0] id_pc_o,
  output logic        id_valid_o,
  output logic        id_exc_o,
  output logic [3:0]  id_exc_code_o
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HOLD, S_DISCARD, S_HALT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_dis_addr, w_dis_addr_nxt;
  logic [31:0] r_id_instr, w_id_instr_nxt, r_id_pc, w_id_pc_nxt;
  logic        r_id_valid, w_id_valid_nxt, r_id_exc, w_id_exc_nxt;
  logic [3:0]  r_id_code, w_id_code_nxt;
  logic        r_skid_valid, w_skid_valid_nxt, r_skid_exc, w_skid_exc_nxt;
  logic [31:0] r_skid_instr, w_skid_instr_nxt, r_skid_pc, w_skid_pc_nxt;
  logic [3:0]  r_skid_code, w_skid_code_nxt;

  // entry produced by the fetch side this cycle, routed to IF/ID or skid
  logic        w_ent_vld, w_ent_exc;
  logic [31:0] w_ent_instr, w_ent_pc;
  logic [3:0]  w_ent_code;

  logic w_cyc, w_resp, w_misal;

  assign w_resp  = iport_ack_i | iport_err_i;
  assign w_misal = |r_pc[1:0];

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_dis_addr_nxt   = r_dis_addr;
    w_id_instr_nxt   = r_id_instr;
    w_id_pc_nxt      = r_id_pc;
    w_id_valid_nxt   = r_id_valid;
    w_id_exc_nxt     = r_id_exc;
    w_id_code_nxt    = r_id_code;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_exc_nxt   = r_skid_exc;
    w_skid_code_nxt  = r_skid_code;
    w_ent_vld        = 1'b0;
    w_ent_instr      = NOP_INST;
    w_ent_pc         = r_pc;
    w_ent_exc        = 1'b0;
    w_ent_code       = 4'd0;
    w_cyc            = 1'b0;

    // ID consumes the current entry when not stalled; bubble unless refilled
    if (!if_stall_i) begin
      w_id_valid_nxt = 1'b0;
      w_id_instr_nxt = NOP_INST;
      w_id_exc_nxt   = 1'b0;
      w_id_code_nxt  = 4'd0;
    end

    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        w_dis_addr_nxt = r_pc;
        if (w_misal) begin
          // no bus request; report misalignment once ID can take it
          if (!if_stall_i) begin
            w_ent_vld   = 1'b1;
            w_ent_exc   = 1'b1;
            w_state_nxt = S_HALT;
          end
        end else begin
          w_cyc = 1'b1;
          if (iport_err_i) begin
            w_ent_vld   = 1'b1;
            w_ent_exc   = 1'b1;
            w_ent_code  = 4'd1;
            w_state_nxt = S_HALT;
          end else if (iport_ack_i) begin
            w_ent_vld   = 1'b1;
            w_ent_instr = iport_dat_i;
            w_pc_nxt    = r_pc + 32'd4;
            if (if_stall_i) w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!if_stall_i) w_state_nxt = S_FETCH;
      end
      S_DISCARD: begin
        w_cyc = 1'b1;
        if (w_resp) w_state_nxt = S_FETCH;
      end
      S_HALT: ;
      default: w_state_nxt = S_IDLE;
    endcase

    // drain a parked entry (HOLD, or an error parked on the way into HALT)
    if (!if_stall_i && r_skid_valid) begin
      w_id_valid_nxt   = 1'b1;
      w_id_instr_nxt   = r_skid_instr;
      w_id_pc_nxt      = r_skid_pc;
      w_id_exc_nxt     = r_skid_exc;
      w_id_code_nxt    = r_skid_code;
      w_skid_valid_nxt = 1'b0;
    end

    if (w_ent_vld) begin
      if (if_stall_i) begin
        w_skid_valid_nxt = 1'b1;
        w_skid_instr_nxt = w_ent_instr;
        w_skid_pc_nxt    = w_ent_pc;
        w_skid_exc_nxt   = w_ent_exc;
        w_skid_code_nxt  = w_ent_code;
      end else begin
        w_id_valid_nxt = 1'b1;
        w_id_instr_nxt = w_ent_instr;
        w_id_pc_nxt    = w_ent_pc;
        w_id_exc_nxt   = w_ent_exc;
        w_id_code_nxt  = w_ent_code;
      end
    end

    // redirect overrides everything, stall included
    if (pc_redirect_i) begin
      w_pc_nxt         = pc_target_i;
      w_id_valid_nxt   = 1'b0;
      w_id_instr_nxt   = NOP_INST;
      w_id_exc_nxt     = 1'b0;
      w_id_code_nxt    = 4'd0;
      w_skid_valid_nxt = 1'b0;
      // a request still open on the bus must be completed before refetching
      if ((r_state == S_FETCH && w_cyc && !w_resp) ||
          (r_state == S_DISCARD && !w_resp))
        w_state_nxt = S_DISCARD;
      else
        w_state_nxt = S_FETCH;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_ADDR;
      r_dis_addr   <= RESET_ADDR;
      r_id_instr   <= NOP_INST;
      r_id_pc      <= 32'd0;
      r_id_valid   <= 1'b0;
      r_id_exc     <= 1'b0;
      r_id_code    <= 4'd0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= NOP_INST;
      r_skid_pc    <= 32'd0;
      r_skid_exc   <= 1'b0;
      r_skid_code  <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_dis_addr   <= w_dis_addr_nxt;
      r_id_instr   <= w_id_instr_nxt;
      r_id_pc      <= w_id_pc_nxt;
      r_id_valid   <= w_id_valid_nxt;
      r_id_exc     <= w_id_exc_nxt;
      r_id_code    <= w_id_code_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_exc   <= w_skid_exc_nxt;
      r_skid_code  <= w_skid_code_nxt;
    end
  end

  assign iport_addr_o     = (r_state == S_DISCARD) ? r_dis_addr : r_pc;
  assign iport_cyc_o      = w_cyc;
  assign iport_stb_o      = w_cyc;
  assign id_instruction_o = r_id_instr;
  assign id_pc_o          = r_id_pc;
  assign id_valid_o       = r_id_valid;
  assign id_exc_o         = r_id_exc;
  assign id_exc_code_o    = r_id_code;

endmodule

// File: tb/tb_morty_if_stage.sv
// Bench for morty_if_stage: transaction-level reference model (PC, pending
// queue, mode flags) checked every cycle, directed scenarios with literal
// expectations, then randomized stall/redirect/wait-state/error traffic.
module tb_morty_if_stage;
  localparam logic [31:0] RST_A = 32'h8000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, redir, stall;
  logic [31:0] tgt, addr, dat;
  logic        cyc, stb, ack, err;
  logic [31:0] id_ins, id_pc;
  logic        id_v, id_e;
  logic [3:0]  id_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  morty_if_stage dut (
    .clk_i(clk), .rst_i(rst), .pc_redirect_i(redir), .pc_target_i(tgt),
    .if_stall_i(stall), .iport_addr_o(addr), .iport_cyc_o(cyc),
    .iport_stb_o(stb), .iport_dat_i(dat), .iport_ack_i(ack),
    .iport_err_i(err), .id_instruction_o(id_ins), .id_pc_o(id_pc),
    .id_valid_o(id_v), .id_exc_o(id_e), .id_exc_code_o(id_c)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        v;
    logic        e;
    logic [3:0]  c;
  } ent_t;

  // reference model
  logic [31:0] m_pc, m_old;
  bit          m_start, m_drain, m_halt;
  ent_t        m_pres;
  ent_t        m_pend[$];

  // memory responder
  int          w_n, w_cnt;
  logic [31:0] err_addr;
  bit          rnd_err, rnd_wait;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit m_cyc();
    return !m_start && !m_halt &&
           (m_drain || (m_pend.size() == 0 && m_pc[1:0] == 2'b00));
  endfunction

  function automatic logic [31:0] m_addr();
    return m_drain ? m_old : m_pc;
  endfunction

  task automatic m_reset();
    m_pc = RST_A; m_old = RST_A;
    m_start = 1; m_drain = 0; m_halt = 0;
    m_pend.delete();
    m_pres = {NOP, 32'h0, 1'b0, 1'b0, 4'h0};
  endtask

  task automatic m_deliver(input ent_t e);
    if (!stall) m_pres = e;
    else m_pend.push_back(e);
  endtask

  task automatic m_step();
    bit   busy, resp, acc;
    ent_t bub;
    acc  = !stall;
    busy = m_cyc();
    resp = ack | err;
    bub  = {NOP, m_pres.pc, 1'b0, 1'b0, 4'h0};
    if (redir) begin
      if (busy && !resp) begin
        if (!m_drain) m_old = m_pc;
        m_drain = 1;
      end else m_drain = 0;
      m_pc = tgt; m_pres = bub; m_pend.delete(); m_halt = 0; m_start = 0;
    end else if (m_start) begin
      m_start = 0;
      if (acc) m_pres = bub;
    end else if (m_drain) begin
      if (resp) m_drain = 0;
      if (acc) m_pres = bub;
    end else if (m_halt || m_pend.size() != 0) begin
      if (acc) begin
        if (m_pend.size() != 0) m_pres = m_pend.pop_front();
        else m_pres = bub;
      end
    end else if (m_pc[1:0] != 2'b00) begin
      if (acc) begin
        m_pres = {NOP, m_pc, 1'b1, 1'b1, 4'd0};
        m_halt = 1;
      end
    end else if (err) begin
      m_halt = 1;
      m_deliver({NOP, m_pc, 1'b1, 1'b1, 4'd1});
    end else if (ack) begin
      m_deliver({dat, m_pc, 1'b1, 1'b0, 4'd0});
      m_pc = m_pc + 32'd4;
    end else if (acc) m_pres = bub;
  endtask

  task automatic compare();
    chk("cyc", {31'b0, cyc}, {31'b0, m_cyc()});
    chk("stb", {31'b0, stb}, {31'b0, m_cyc()});
    chk("addr", addr, m_addr());
    chk("valid", {31'b0, id_v}, {31'b0, m_pres.v});
    chk("instr", id_ins, m_pres.ins);
    if (m_pres.v) chk("id_pc", id_pc, m_pres.pc);
    chk("exc", {31'b0, id_e}, {31'b0, m_pres.e});
    chk("exc_code", {28'b0, id_c}, {28'b0, m_pres.c});
  endtask

  task automatic respond();
    ack = 0; err = 0;
    if (cyc && stb) begin
      if (w_cnt >= w_n) begin
        ack = 1; dat = addr ^ 32'h13;
        if (addr == err_addr || (rnd_err && $urandom_range(0, 19) == 0)) begin
          err = 1; ack = 1'($urandom_range(0, 1));
        end
        w_cnt = 0;
        if (rnd_wait) w_n = $urandom_range(0, 3);
      end else w_cnt++;
    end else begin
      w_cnt = 0;
      if (rnd_err && $urandom_range(0, 15) == 0) begin
        ack = 1; dat = $urandom;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) m_reset();
    else m_step();
    @(negedge clk);
    compare();
    respond();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found, seen_bad;
    rst = 1; redir = 0; tgt = 0; stall = 0; ack = 0; err = 0; dat = 0;
    w_n = 0; w_cnt = 0; err_addr = 32'h1; rnd_err = 0; rnd_wait = 0;
    m_reset();

    // reset values
    @(negedge clk);
    compare();
    chk("rst_addr", addr, RST_A);
    chk("rst_cyc", {31'b0, cyc}, 32'd0);
    chk("rst_instr", id_ins, NOP);
    chk("rst_id_pc", id_pc, 32'h0);
    rst = 0;
    respond();

    // zero-wait streaming
    cycle();
    chk("stream_a0", addr, 32'h8000_0000);
    chk("stream_cyc", {31'b0, cyc}, 32'd1);
    cycle();
    chk("stream_a1", addr, 32'h8000_0004);
    chk("stream_v1", {31'b0, id_v}, 32'd1);
    chk("stream_pc1", id_pc, 32'h8000_0000);
    chk("stream_ins1", id_ins, 32'h8000_0013);
    cycle();
    chk("stream_a2", addr, 32'h8000_0008);
    chk("stream_pc2", id_pc, 32'h8000_0004);

    // stall while an ack lands
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_frozen_pc", id_pc, 32'h8000_0004);
    end
    stall = 0;
    cycle();
    chk("skid_pc", id_pc, 32'h8000_0008);
    chk("skid_v", {31'b0, id_v}, 32'd1);
    w_n = 3;
    cycle();
    chk("after_skid_pc", id_pc, 32'h8000_000C);

    // redirect while a 3-wait request is outstanding
    redir = 1; tgt = 32'h8000_0100;
    cycle();
    redir = 0;
    chk("discard_addr", addr, 32'h8000_0010);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (cyc && addr == 32'h8000_0100) found = 1;
    end
    chk("redirect_fetch", {31'b0, found}, 32'd1);

    // misaligned redirect
    w_n = 0;
    redir = 1; tgt = 32'h8000_0102;
    cycle();
    redir = 0;
    found = 0; seen_bad = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (cyc && addr == 32'h8000_0102) seen_bad = 1;
      if (id_v && id_e) found = 1;
    end
    chk("misal_found", {31'b0, found}, 32'd1);
    chk("misal_no_stb", {31'b0, seen_bad}, 32'd0);
    chk("misal_code", {28'b0, id_c}, 32'd0);
    chk("misal_pc", id_pc, 32'h8000_0102);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("halt_cyc", {31'b0, cyc}, 32'd0);
    end
    redir = 1; tgt = 32'h8000_0200;
    cycle();
    redir = 0;
    chk("resume_addr", addr, 32'h8000_0200);
    chk("resume_cyc", {31'b0, cyc}, 32'd1);

    // bus error
    err_addr = 32'h8000_0010;
    redir = 1; tgt = 32'h8000_0010;
    cycle();
    redir = 0;
    cycle();
    chk("err_exc", {31'b0, id_e}, 32'd1);
    chk("err_code", {28'b0, id_c}, 32'd1);
    chk("err_pc", id_pc, 32'h8000_0010);
    chk("err_cyc", {31'b0, cyc}, 32'd0);
    redir = 1; stall = 1; tgt = 32'h8000_0300;
    cycle();
    chk("redir_over_stall", {31'b0, id_v}, 32'd0);
    redir = 0; stall = 0; err_addr = 32'h1;

    // reset in the middle of a 2-wait request
    w_n = 2;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (cyc && w_cnt == 1) found = 1;
    end
    chk("mid_req_found", {31'b0, found}, 32'd1);
    #2 rst = 1;
    #1;
    chk("async_rst_cyc", {31'b0, cyc}, 32'd0);
    chk("async_rst_stb", {31'b0, stb}, 32'd0);
    chk("async_rst_v", {31'b0, id_v}, 32'd0);
    chk("async_rst_ins", id_ins, NOP);
    chk("async_rst_addr", addr, RST_A);
    m_reset();
    w_cnt = 0; ack = 0; err = 0;
    cycle();
    rst = 0; ack = 1; dat = 32'hDEAD_BEEF;
    cycle();
    chk("restart_addr", addr, RST_A);
    chk("restart_cyc", {31'b0, cyc}, 32'd1);

    // randomized traffic
    rnd_err = 1; rnd_wait = 1;
    for (int i = 0; i < 4000; i++) begin
      rst   = 0;
      stall = ($urandom_range(0, 3) == 0);
      redir = ($urandom_range(0, 11) == 0);
      tgt   = 32'h8000_0000 + 32'($urandom_range(0, 63)) * 32'd4;
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFF8;
      if ($urandom_range(0, 599) == 0) rst = 1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
